uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Serial transmitter consuming the UART controller configuration outputs (uart_enable, uart_mode, uart_rate).
- Returns uart_busy, uart_error and update_ok to the configuration register file.
- Accepts bytes over a valid/ready handshake and drives an 8-bit async frame on txd.
- Config is shadow-latched at frame start, so register writes never corrupt a frame in flight.

Parameters:
- DATA_BITS, 8, payload bits per frame (fixed at 8 for this revision).
- MIN_DIV, 2, smallest legal uart_rate (cycles per bit).
- FIFO_DEPTH, 4, entries in the optional TX FIFO (power of two).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- uart_enable  in  1  transmitter enable from config regs
- uart_mode  in  3  [0]=parity en, [1]=odd parity, [2]=two stop bits
- uart_rate  in  16  bit period in clk cycles
- tx_valid  in  1  byte offered
- tx_data  in  8  byte to send
- tx_ready  out  1  byte accepted when tx_valid&&tx_ready
- err_clr  in  1  clears sticky uart_error
- txd  out  1  serial line, idle high
- uart_busy  out  1  frame in progress
- uart_error  out  1  sticky config error
- update_ok  out  1  engine idle, config may change safely

Behaviour:
- Reset (async, immediate):
  - txd=1, uart_busy=0, uart_error=0, update_ok=1, tx_ready=0, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame and txd returns high at once.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, update_ok=1, uart_busy=0.
  - tx_ready = uart_enable && (uart_rate >= MIN_DIV).
  - On accept: latch tx_data, uart_mode and uart_rate into shadow registers, then go to START next cycle.
- Bit timing:
  - Each bit is held exactly R cycles, where R is the shadowed rate.
  - Baud counter loads R-1 and counts down; the bit advances when it reaches 0.
- Frame sequence:
  - START: txd=0.
  - DATA: 8 bits, LSB first; 3-bit index, wraps 7->0 on exit.
  - PARITY (only if mode[0]): even parity = XOR of data; odd parity = its inverse.
  - STOP: txd=1 for R cycles, or 2R if mode[2].
  - After STOP, go to IDLE.
- Frame length: R*(10 + mode[0] + mode[2]) cycles.
- Inter-frame gap: at least one IDLE cycle between frames (txd high).
- In every non-IDLE state: uart_busy=1, update_ok=0, tx_ready=0.
- Config changes mid-frame (enable, mode, rate) have no effect until the next accept.
- uart_enable dropping mid-frame: the current frame completes; no new accept.
- uart_error:
  - Set when, in IDLE, a byte is pending and uart_enable=1 and uart_rate < MIN_DIV.
  - Stays set until err_clr; if set and clear occur in the same cycle, set wins.
- tx_data is ignored unless accepted; tx_valid may drop without an accept.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the FSM, and tx_ready = !fifo_full, independent of config.
  - The FSM pops one byte per frame when in IDLE, FIFO non-empty, uart_enable=1 and rate is valid; the config shadow latches on the pop.
  - "Byte pending" for uart_error means FIFO non-empty.
  - uart_busy = FSM busy || FIFO non-empty.
  - update_ok is unchanged: FSM in IDLE.
- Undefined: no FIFO; behaviour exactly as described above.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum.
  - Mode bit index constants MODE_PAR_EN=0, MODE_PAR_ODD=1, MODE_STOP2=2.
  - MIN_DIV default; UART_RESET_RATE=9600.
- Sub-module uart_tx_fifo (sync FIFO with full/empty flags), instantiated only under UART_TX_FIFO_EN.

Test Plan:
- rate=4, mode=0, send 0xA5 -> txd = 0, then 1,0,1,0,0,1,0,1, then 1; each level 4 cycles; uart_busy high 40 cycles.
- rate=4, mode=3'b001, send 0x07 -> parity bit 1, frame 44 cycles; mode=3'b011 -> parity bit 0.
- rate=3, mode=3'b100, send 0xFF -> stop held 6 cycles, frame 33 cycles; next accept no earlier than 1 cycle after STOP ends.
- Mid-frame change:
  - Start a frame at rate=4; rewrite rate=8 and mode=3'b001 at cycle 10.
  - Current frame stays 40 cycles with no parity; update_ok=0 throughout.
  - The next frame uses 8 cycles/bit with parity.
- rate=1, uart_enable=1, tx_valid=1 -> tx_ready=0 and uart_error=1 next cycle; err_clr with tx_valid=0 -> uart_error=0; txd stays 1.
- Assert rst during DATA -> txd=1, uart_busy=0, update_ok=1 in the same cycle; after release, a new 0x3C frame is sent cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM state encoding,
// uart_mode bit positions and default rate limits.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int MODE_PAR_EN  = 0;
    localparam int MODE_PAR_ODD = 1;
    localparam int MODE_STOP2   = 2;

    localparam int          MIN_DIV_DEFAULT = 2;
    localparam logic [15:0] UART_RESET_RATE = 16'd9600;

    // Even parity is the XOR of the payload; odd parity inverts it.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags, placed in front of the
// transmitter FSM when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: one 8-bit async frame per accepted byte, config shadowed at
// frame start. Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int MIN_DIV    = MIN_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_enable,
    input  logic [2:0]           uart_mode,
    input  logic [15:0]          uart_rate,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 err_clr,
    output logic                 txd,
    output logic                 uart_busy,
    output logic                 uart_error,
    output logic                 update_ok
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fifo_depth_check
        $error("FIFO_DEPTH must be a power of two of at least 2");
    end

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [15:0]          baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_second;
    logic [DATA_BITS-1:0] sh_data;
    logic [2:0]           sh_mode;
    logic [15:0]          sh_rate;

    logic                 rate_ok;
    logic                 bit_done;
    logic                 pending;
    logic                 start_frame;
    logic                 fifo_busy;
    logic [DATA_BITS-1:0] src_data;

    assign rate_ok  = (uart_rate >= 16'(MIN_DIV));
    assign bit_done = (baud_cnt == 16'd0);

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    // Producers see only FIFO space; config gating moves to the pop side.
    assign tx_ready    = !rst && !fifo_full;
    assign pending     = !fifo_empty;
    assign start_frame = (state == ST_IDLE) && pending && uart_enable && rate_ok;
    assign src_data    = fifo_rd_data;
    assign fifo_busy   = !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid && tx_ready),
        .wr_data (tx_data),
        .pop     (start_frame),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
`else
    logic accept_ok;

    assign accept_ok   = (state == ST_IDLE) && uart_enable && rate_ok;
    assign tx_ready    = !rst && accept_ok;
    assign pending     = tx_valid;
    assign start_frame = tx_valid && accept_ok;
    assign src_data    = tx_data;
    assign fifo_busy   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start_frame) state_nxt = ST_START;
            ST_START:  if (bit_done) state_nxt = ST_DATA;
            ST_DATA:   if (bit_done && (bit_idx == LAST_IDX))
                           state_nxt = sh_mode[MODE_PAR_EN] ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done) state_nxt = ST_STOP;
            ST_STOP:   if (bit_done && (!sh_mode[MODE_STOP2] || stop_second))
                           state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        txd       = 1'b1;
        uart_busy = (state != ST_IDLE) || fifo_busy;
        update_ok = (state == ST_IDLE);
        unique case (state)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = sh_data[bit_idx];
            ST_PARITY: txd = calc_parity(sh_data, sh_mode[MODE_PAR_ODD]);
            default:   txd = 1'b1;
        endcase
    end

    // Baud counter loads R-1 per bit; a two-stop frame reloads once more in STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
        end else if (state == ST_IDLE) begin
            stop_second <= 1'b0;
            if (start_frame) baud_cnt <= uart_rate - 16'd1;
        end else if (bit_done) begin
            baud_cnt <= sh_rate - 16'd1;
            if (state == ST_DATA) bit_idx <= bit_idx + 1'b1;
            if (state == ST_STOP) stop_second <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start_frame) begin
            sh_data <= src_data;
            sh_mode <= uart_mode;
            sh_rate <= uart_rate;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            uart_error <= 1'b0;
        else if ((state == ST_IDLE) && pending && uart_enable && !rate_ok)
            uart_error <= 1'b1;
        else if (err_clr)
            uart_error <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine (default build): directed frames with
// literal expectations plus randomized traffic against a frame-level model.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_enable;
    logic [2:0]  uart_mode;
    logic [15:0] uart_rate;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        err_clr;
    logic        txd;
    logic        uart_busy;
    logic        uart_error;
    logic        update_ok;

    int total = 0;
    int bad   = 0;

    // Model: one queue entry per clock cycle of expected txd level while busy.
    logic exp_q[$];
    logic m_err = 1'b0;
    logic m_idle;
    logic m_acc;

    always #5 clk = ~clk;

    uart_tx_engine dut (
        .clk         (clk),
        .rst         (rst),
        .uart_enable (uart_enable),
        .uart_mode   (uart_mode),
        .uart_rate   (uart_rate),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .err_clr     (err_clr),
        .txd         (txd),
        .uart_busy   (uart_busy),
        .uart_error  (uart_error),
        .update_ok   (update_ok)
    );

    task automatic push_frame(input logic [7:0] d, input logic [2:0] m, input int r);
        logic lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(d[i]);
        if (m[0]) lv.push_back((^d) ^ m[1]);
        lv.push_back(1'b1);
        if (m[2]) lv.push_back(1'b1);
        foreach (lv[i]) repeat (r) exp_q.push_back(lv[i]);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_err = 1'b0;
        end else begin
            m_idle = (exp_q.size() == 0);
            m_acc  = m_idle && tx_valid && uart_enable && (uart_rate >= 16'd2);
            if (m_idle && tx_valid && uart_enable && (uart_rate < 16'd2)) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (!m_idle) void'(exp_q.pop_front());
            if (m_acc) push_frame(tx_data, uart_mode, int'(uart_rate));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept_byte(input logic [7:0] d, input logic [2:0] m,
                               input logic [15:0] r, output int waited);
        logic ok;
        ok          = 1'b0;
        waited      = 0;
        uart_mode   = m;
        uart_rate   = r;
        tx_data     = d;
        tx_valid    = 1'b1;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic capture(input int r, input int chg_at, input logic [15:0] chg_rate,
                           input logic [2:0] chg_mode, output int len, output logic [11:0] bits);
        int c;
        c    = 0;
        bits = '0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!uart_busy) break;
            if ((c % r) == (r / 2) && (c / r) < 12) bits[c / r] = txd;
            if (c == chg_at) begin
                #1;
                uart_rate = chg_rate;
                uart_mode = chg_mode;
            end
            c++;
        end
        #1;
        len = c;
    endtask

    initial begin
        int          len;
        int          waited;
        logic [11:0] bits;

        rst         = 1'b1;
        uart_enable = 1'b1;
        uart_mode   = 3'b000;
        uart_rate   = 16'd4;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        err_clr     = 1'b0;

        fork
            begin : compare_loop
                logic e_busy;
                logic e_txd;
                logic e_ready;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        chk("rst_txd", txd, 1);
                        chk("rst_busy", uart_busy, 0);
                        chk("rst_update_ok", update_ok, 1);
                        chk("rst_tx_ready", tx_ready, 0);
                        chk("rst_error", uart_error, 0);
                    end else begin
                        e_busy  = (exp_q.size() != 0);
                        e_txd   = e_busy ? exp_q[0] : 1'b1;
                        e_ready = !e_busy && uart_enable && (uart_rate >= 16'd2);
                        chk("txd", txd, e_txd);
                        chk("uart_busy", uart_busy, e_busy);
                        chk("update_ok", update_ok, !e_busy);
                        chk("tx_ready", tx_ready, e_ready);
                        chk("uart_error", uart_error, m_err);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd", txd, 1);
        chk("reset_busy", uart_busy, 0);
        chk("reset_update_ok", update_ok, 1);
        chk("reset_tx_ready", tx_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 0xA5, rate 4, no parity, one stop
        accept_byte(8'hA5, 3'b000, 16'd4, waited);
        capture(4, -1, 16'd0, 3'b000, len, bits);
        chk("a5_len", len, 40);
        chk("a5_bits", bits, 12'h34A);

        // 0x07 even then odd parity
        accept_byte(8'h07, 3'b001, 16'd4, waited);
        capture(4, -1, 16'd0, 3'b000, len, bits);
        chk("even_par_len", len, 44);
        chk("even_par_bits", bits, 12'h60E);
        accept_byte(8'h07, 3'b011, 16'd4, waited);
        capture(4, -1, 16'd0, 3'b000, len, bits);
        chk("odd_par_len", len, 44);
        chk("odd_par_bits", bits, 12'h40E);

        // Two stop bits at rate 3, then back-to-back offer after STOP
        accept_byte(8'hFF, 3'b100, 16'd3, waited);
        capture(3, -1, 16'd0, 3'b000, len, bits);
        chk("stop2_len", len, 33);
        chk("stop2_bits", bits, 12'h7FE);
        accept_byte(8'h00, 3'b000, 16'd3, waited);
        chk("gap_wait", waited, 0);
        capture(3, -1, 16'd0, 3'b000, len, bits);
        chk("zero_len", len, 30);
        chk("zero_bits", bits, 12'h200);

        // Config rewritten mid-frame only affects the next frame
        accept_byte(8'h5A, 3'b000, 16'd4, waited);
        capture(4, 10, 16'd8, 3'b001, len, bits);
        chk("midchg_len", len, 40);
        chk("midchg_bits", bits, 12'h2B4);
        accept_byte(8'h5A, 3'b001, 16'd8, waited);
        capture(8, -1, 16'd0, 3'b000, len, bits);
        chk("next_len", len, 88);
        chk("next_bits", bits, 12'h4B4);

        // Illegal rate raises sticky error; set beats clear
        uart_rate = 16'd1;
        tx_valid  = 1'b1;
        #1;
        chk("badrate_ready", tx_ready, 0);
        @(posedge clk);
        #1;
        chk("badrate_error", uart_error, 1);
        chk("badrate_txd", txd, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("set_wins_error", uart_error, 1);
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("cleared_error", uart_error, 0);
        chk("cleared_txd", txd, 1);
        uart_enable = 1'b0;
        tx_valid    = 1'b1;
        @(posedge clk);
        #1;
        chk("disabled_no_error", uart_error, 0);
        uart_enable = 1'b1;
        tx_valid    = 1'b0;

        // Reset during DATA drops the line high immediately
        accept_byte(8'h99, 3'b000, 16'd4, waited);
        repeat (14) @(negedge clk);
        #1;
        chk("pre_rst_txd", txd, 0);
        rst = 1'b1;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", uart_busy, 0);
        chk("midrst_update_ok", update_ok, 1);
        chk("midrst_tx_ready", tx_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        accept_byte(8'h3C, 3'b000, 16'd4, waited);
        capture(4, -1, 16'd0, 3'b000, len, bits);
        chk("post_rst_len", len, 40);
        chk("post_rst_bits", bits, 12'h278);

        // Randomized traffic and config churn, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            err_clr  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0)
                uart_rate = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1))
                                                        : 16'($urandom_range(2, 5));
            if ($urandom_range(0, 19) == 0) uart_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) uart_enable = ($urandom_range(0, 5) != 0);
        end
        tx_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("final_idle_busy", uart_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
